// File: rtl/magic_match_pkg.sv
// -----------------------------------------------------------------------------
// magic_match_pkg
// Shared definitions for the template matcher:
//   state_t      controller states (IDLE -> ACCUM -> SELECT -> OUTPUT -> COOLDOWN)
//   DEF_*        default geometry and timing constants
//   clogw()      ceil(log2(n)) clamped to at least 1, for sizing counters/indices
// -----------------------------------------------------------------------------
package magic_match_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_SELECT,
      S_OUTPUT,
      S_COOLDOWN
   } state_t;

   localparam int DEF_IMG_W        = 30;
   localparam int DEF_IMG_H        = 30;
   localparam int DEF_N_CLASS      = 10;
   localparam int DEF_LANES        = 1;
   localparam int DEF_CNT_W        = 16;
   localparam int DEF_COOLDOWN_CYC = 50000000;

   // Width able to index n distinct values (never narrower than one bit).
   function automatic int clogw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/magic_ratio_cmp.sv
// -----------------------------------------------------------------------------
// magic_ratio_cmp
// Combinational exact ratio compare: asserts o_b_wins when
// son_b/mom_b > son_a/mom_a, evaluated by cross multiplication so that no
// division is needed and mom = 0 behaves deterministically (never wins).
// Ports:
//   i_son_a, i_mom_a   current best score pair
//   i_son_b, i_mom_b   challenger score pair
//   o_b_wins           challenger strictly better
// -----------------------------------------------------------------------------
module magic_ratio_cmp #(
   parameter int CNT_W = 16
) (
   input  logic [CNT_W-1:0] i_son_a,
   input  logic [CNT_W-1:0] i_mom_a,
   input  logic [CNT_W-1:0] i_son_b,
   input  logic [CNT_W-1:0] i_mom_b,
   output logic             o_b_wins
);

   logic [2*CNT_W-1:0] w_lhs;
   logic [2*CNT_W-1:0] w_rhs;

   assign w_lhs    = {{CNT_W{1'b0}}, i_son_b} * {{CNT_W{1'b0}}, i_mom_a};
   assign w_rhs    = {{CNT_W{1'b0}}, i_son_a} * {{CNT_W{1'b0}}, i_mom_b};
   // Strict compare: equal ratios keep the lower-indexed incumbent.
   assign o_b_wins = (w_lhs > w_rhs);

endmodule

// File: rtl/magic_template_matcher.sv
// -----------------------------------------------------------------------------
// magic_template_matcher
// Scores a binary image against N_CLASS binary templates with the son/mom
// overlap metric (both set: son+=2, mom+=2; exactly one set: mom+=1) and
// reports the class with the highest son/mom ratio, lowest index on ties.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           start request, sampled only in IDLE
//   i_image           IMG_W*IMG_H pixels, bit y*IMG_W+x, stable while busy
//   i_masks           N_CLASS templates, template c at [c*NPIX +: NPIX]
//   o_busy            high outside IDLE
//   o_digit           winning class index
//   o_son, o_mom      winner's score pair
//   o_valid, i_ready  result handshake
// -----------------------------------------------------------------------------
module magic_template_matcher
   import magic_match_pkg::*;
#(
   parameter int IMG_W        = DEF_IMG_W,
   parameter int IMG_H        = DEF_IMG_H,
   parameter int N_CLASS      = DEF_N_CLASS,
   parameter int LANES        = DEF_LANES,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_start,
   input  logic [IMG_W*IMG_H-1:0]           i_image,
   input  logic [N_CLASS*IMG_W*IMG_H-1:0]   i_masks,
   output logic                             o_busy,
   output logic [clogw(N_CLASS)-1:0]        o_digit,
   output logic [CNT_W-1:0]                 o_son,
   output logic [CNT_W-1:0]                 o_mom,
   output logic                             o_valid,
   input  logic                             i_ready
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int PTR_W = clogw(NPIX);
   localparam int IDX_W = clogw(N_CLASS * NPIX);
   localparam int DIG_W = clogw(N_CLASS);
   localparam int SEL_W = clogw(N_CLASS + 1);
   localparam int CD_W  = clogw(COOLDOWN_CYC + 1);

   if ((NPIX % LANES) != 0) begin : g_err_lanes
      $error("LANES must divide IMG_W*IMG_H");
   end
   if (CNT_W < $clog2(2 * NPIX + 1)) begin : g_err_cntw
      $error("CNT_W too small for 2*IMG_W*IMG_H");
   end
   if (N_CLASS < 2) begin : g_err_nclass
      $error("N_CLASS must be at least 2");
   end

   state_t             r_state;
   state_t             w_next;

   logic [PTR_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [DIG_W-1:0]   r_best;
   logic [CD_W-1:0]    r_cd;
   logic [CNT_W-1:0]   r_son [N_CLASS];
   logic [CNT_W-1:0]   r_mom [N_CLASS];
   logic [DIG_W-1:0]   r_digit;
   logic [CNT_W-1:0]   r_out_son;
   logic [CNT_W-1:0]   r_out_mom;

   logic [CNT_W-1:0]   w_son_inc [N_CLASS];
   logic [CNT_W-1:0]   w_mom_inc [N_CLASS];
   logic               w_last_grp;
   logic               w_sel_done;
   logic               w_cd_done;
   logic [DIG_W-1:0]   w_k;
   logic               w_b_wins;

   assign w_last_grp = (r_ptr == PTR_W'(NPIX - LANES));
   assign w_sel_done = (r_sel == SEL_W'(N_CLASS));
   assign w_cd_done  = (r_cd == CD_W'(COOLDOWN_CYC - 1));
   // Once every class has been compared r_sel equals N_CLASS; park the
   // challenger index on 0 so the array read stays in range.
   assign w_k        = w_sel_done ? '0 : r_sel[DIG_W-1:0];

   magic_ratio_cmp #(
      .CNT_W (CNT_W)
   ) u_cmp (
      .i_son_a  (r_son[r_best]),
      .i_mom_a  (r_mom[r_best]),
      .i_son_b  (r_son[w_k]),
      .i_mom_b  (r_mom[w_k]),
      .o_b_wins (w_b_wins)
   );

   // ---- controller: state register -----------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---- controller: next state ----------------------------------------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:     if (i_start)    w_next = S_ACCUM;
         S_ACCUM:    if (w_last_grp) w_next = S_SELECT;
         S_SELECT:   if (w_sel_done) w_next = S_OUTPUT;
         S_OUTPUT:   if (i_ready)    w_next = (COOLDOWN_CYC == 0) ? S_IDLE : S_COOLDOWN;
         S_COOLDOWN: if (w_cd_done)  w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   // ---- controller: outputs -------------------------------------------------
   always_comb begin
      o_busy  = (r_state != S_IDLE);
      o_valid = (r_state == S_OUTPUT);
   end

   assign o_digit = r_digit;
   assign o_son   = r_out_son;
   assign o_mom   = r_out_mom;

   // ---- accumulate: per-class sum of all lane contributions this cycle ------
   always_comb begin
      for (int c = 0; c < N_CLASS; c++) begin
         w_son_inc[c] = '0;
         w_mom_inc[c] = '0;
         for (int l = 0; l < LANES; l++) begin
            if (i_image[r_ptr + PTR_W'(l)] &&
                i_masks[IDX_W'(c * NPIX) + IDX_W'(r_ptr) + IDX_W'(l)]) begin
               w_son_inc[c] = w_son_inc[c] + CNT_W'(2);
               w_mom_inc[c] = w_mom_inc[c] + CNT_W'(2);
            end else if (i_image[r_ptr + PTR_W'(l)] ^
                         i_masks[IDX_W'(c * NPIX) + IDX_W'(r_ptr) + IDX_W'(l)]) begin
               w_mom_inc[c] = w_mom_inc[c] + CNT_W'(1);
            end
         end
      end
   end

   // ---- datapath registers --------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr     <= '0;
         r_sel     <= '0;
         r_best    <= '0;
         r_cd      <= '0;
         r_digit   <= '0;
         r_out_son <= '0;
         r_out_mom <= '0;
         for (int c = 0; c < N_CLASS; c++) begin
            r_son[c] <= '0;
            r_mom[c] <= '0;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_ptr <= '0;
                  r_cd  <= '0;
                  for (int c = 0; c < N_CLASS; c++) begin
                     r_son[c] <= '0;
                     r_mom[c] <= '0;
                  end
               end
            end
            S_ACCUM: begin
               r_ptr <= r_ptr + PTR_W'(LANES);
               for (int c = 0; c < N_CLASS; c++) begin
                  r_son[c] <= r_son[c] + w_son_inc[c];
                  r_mom[c] <= r_mom[c] + w_mom_inc[c];
               end
               if (w_last_grp) begin
                  r_sel  <= SEL_W'(1);
                  r_best <= '0;
               end
            end
            S_SELECT: begin
               if (!w_sel_done) begin
                  if (w_b_wins) r_best <= w_k;
                  r_sel <= r_sel + SEL_W'(1);
               end else begin
                  r_digit   <= r_best;
                  r_out_son <= r_son[r_best];
                  r_out_mom <= r_mom[r_best];
               end
            end
            S_OUTPUT: begin
               if (i_ready) r_cd <= '0;
            end
            S_COOLDOWN: begin
               r_cd <= r_cd + CD_W'(1);
            end
            default: begin
               r_ptr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_magic_template_matcher.sv
module tb_magic_template_matcher;
   import magic_match_pkg::*;

   // Instance A: default geometry, short cooldown. Instance B: small corner config.
   localparam int A_W = 30, A_H = 30, A_N = 10, A_L = 1, A_CD = 5;
   localparam int A_NPIX = A_W * A_H;
   localparam int A_DW = clogw(A_N);
   localparam int B_W = 6, B_H = 6, B_N = 4, B_L = 3, B_CD = 20;
   localparam int B_NPIX = B_W * B_H;
   localparam int B_DW = clogw(B_N);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    a_rst, a_start, a_ready, a_busy, a_valid;
   logic [A_NPIX-1:0]       a_img;
   logic [A_N*A_NPIX-1:0]   a_masks;
   logic [A_DW-1:0]         a_digit;
   logic [15:0]             a_son, a_mom;

   logic                    b_rst, b_start, b_ready, b_busy, b_valid;
   logic [B_NPIX-1:0]       b_img;
   logic [B_N*B_NPIX-1:0]   b_masks;
   logic [B_DW-1:0]         b_digit;
   logic [15:0]             b_son, b_mom;

   int vectors = 0;
   int errors  = 0;

   magic_template_matcher #(
      .IMG_W(A_W), .IMG_H(A_H), .N_CLASS(A_N), .LANES(A_L),
      .CNT_W(16), .COOLDOWN_CYC(A_CD)
   ) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_image(a_img),
      .i_masks(a_masks), .o_busy(a_busy), .o_digit(a_digit), .o_son(a_son),
      .o_mom(a_mom), .o_valid(a_valid), .i_ready(a_ready)
   );

   magic_template_matcher #(
      .IMG_W(B_W), .IMG_H(B_H), .N_CLASS(B_N), .LANES(B_L),
      .CNT_W(16), .COOLDOWN_CYC(B_CD)
   ) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_image(b_img),
      .i_masks(b_masks), .o_busy(b_busy), .o_digit(b_digit), .o_son(b_son),
      .o_mom(b_mom), .o_valid(b_valid), .i_ready(b_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: son = 2*|img & mask|, mom = |img| + |mask|; best ratio wins,
   // earliest class kept on equal ratios.
   function automatic void model(input logic [A_NPIX-1:0] img, input logic [A_N*A_NPIX-1:0] masks,
                                 input int npix, input int nc,
                                 output int dig, output int son, output int mom);
      int s [A_N];
      int m [A_N];
      logic [A_NPIX-1:0] mk;
      for (int c = 0; c < nc; c++) begin
         mk = '0;
         for (int p = 0; p < npix; p++) mk[p] = masks[c*npix + p];
         s[c] = 2 * $countones(img & mk);
         m[c] = $countones(img) + $countones(mk);
      end
      dig = 0;
      for (int c = 1; c < nc; c++)
         if (longint'(s[c]) * longint'(m[dig]) > longint'(s[dig]) * longint'(m[c])) dig = c;
      son = s[dig];
      mom = m[dig];
   endfunction

   // Start A, await result, check latency/result, optionally hold ready low,
   // then hand the result off and verify the cooldown window.
   task automatic run_a(input string tag, input int e_dig, input int e_son, input int e_mom,
                        input int hold);
      int n;
      a_start = 1'b1;
      @(posedge clk);
      #1 a_start = 1'b0;
      n = 0;
      while (!a_valid && n < 2000) begin
         @(posedge clk);
         #1 n++;
      end
      check({tag, "_latency"}, n, A_NPIX / A_L + A_N);
      check({tag, "_digit"}, a_digit, e_dig);
      check({tag, "_son"}, a_son, e_son);
      check({tag, "_mom"}, a_mom, e_mom);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, a_valid, 1);
         check({tag, "_hold_digit"}, a_digit, e_dig);
      end
      a_ready = 1'b1;
      @(posedge clk);
      #1 a_ready = 1'b0;
      check({tag, "_valid_drop"}, a_valid, 0);
      check({tag, "_cool_busy"}, a_busy, 1);
      repeat (A_CD - 1) @(posedge clk);
      #1 check({tag, "_cool_last"}, a_busy, 1);
      @(posedge clk);
      #1 check({tag, "_idle"}, a_busy, 0);
      check({tag, "_digit_kept"}, a_digit, e_dig);
   endtask

   task automatic rand_vec(output logic [A_NPIX-1:0] v, input int npix);
      v = '0;
      for (int p = 0; p < npix; p++) v[p] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      logic [A_NPIX-1:0] t, t3;
      int dig, son, mom, n, idle_seen, noise;

      a_rst = 1'b1; a_start = 1'b0; a_ready = 1'b0; a_img = '0; a_masks = '0;
      b_rst = 1'b1; b_start = 1'b1; b_ready = 1'b0; b_img = '0; b_masks = '0;
      #1;
      check("rst_busy", a_busy, 0);
      check("rst_valid", a_valid, 0);
      check("rst_digit", a_digit, 0);
      check("rst_son", a_son, 0);
      check("rst_mom", a_mom, 0);
      check("rst_b_valid", b_valid, 0);
      repeat (2) @(posedge clk);
      #1 a_rst = 1'b0;
      @(posedge clk);
      #1;

      // All-zero image, template c has c+1 set pixels: all son 0, class 0 wins.
      a_img = '0; a_masks = '0;
      for (int c = 0; c < A_N; c++)
         for (int p = 0; p <= c; p++) a_masks[c*A_NPIX + p] = 1'b1;
      run_a("zero_img", 0, 0, 1, 0);

      // Image equal to template 3, other templates disjoint from it.
      rand_vec(t3, A_NPIX);
      t3[0] = 1'b1;
      for (int c = 0; c < A_N; c++) begin
         rand_vec(t, A_NPIX);
         a_masks[c*A_NPIX +: A_NPIX] = (c == 3) ? t3 : (t & ~t3);
      end
      a_img = t3;
      run_a("match3", 3, 2 * $countones(t3), 2 * $countones(t3), 0);

      // Templates 2 and 7 both exactly equal the image: lower index wins;
      // result held while ready stays low for 100 cycles.
      rand_vec(t3, A_NPIX);
      t3[5] = 1'b1;
      a_img = t3;
      for (int c = 0; c < A_N; c++) begin
         rand_vec(t, A_NPIX);
         a_masks[c*A_NPIX +: A_NPIX] = (c == 2 || c == 7) ? t3 : t;
      end
      run_a("tie27", 2, 2 * $countones(t3), 2 * $countones(t3), 100);

      // Random images with templates that are noisy copies of the image.
      for (int r = 0; r < 3; r++) begin
         rand_vec(t3, A_NPIX);
         a_img = t3;
         for (int c = 0; c < A_N; c++) begin
            noise = $urandom_range(2, 12);
            for (int p = 0; p < A_NPIX; p++)
               a_masks[c*A_NPIX + p] = ($urandom_range(0, noise - 1) == 0) ? ~t3[p] : t3[p];
         end
         model(a_img, a_masks, A_NPIX, A_N, dig, son, mom);
         run_a($sformatf("rand%0d", r), dig, son, mom, 0);
      end

      // Reset during ACCUM: everything clears at once, next run is clean.
      a_start = 1'b1;
      @(posedge clk);
      #1 a_start = 1'b0;
      repeat (400) @(posedge clk);
      #1 a_rst = 1'b1;
      #1;
      check("midrst_busy", a_busy, 0);
      check("midrst_valid", a_valid, 0);
      check("midrst_digit", a_digit, 0);
      check("midrst_son", a_son, 0);
      check("midrst_mom", a_mom, 0);
      #1 a_rst = 1'b0;
      @(negedge clk);
      rand_vec(t3, A_NPIX);
      a_img = t3;
      for (int c = 0; c < A_N; c++) begin
         rand_vec(t, A_NPIX);
         a_masks[c*A_NPIX +: A_NPIX] = t;
      end
      model(a_img, a_masks, A_NPIX, A_N, dig, son, mom);
      run_a("after_rst", dig, son, mom, 0);

      // Instance B: start held high, 3 lanes, 20-cycle cooldown.
      for (int p = 0; p < B_NPIX; p++) b_img[p] = 1'($urandom_range(0, 1));
      for (int p = 0; p < B_N*B_NPIX; p++) b_masks[p] = 1'($urandom_range(0, 1));
      model(A_NPIX'(b_img), (A_N*A_NPIX)'(b_masks), B_NPIX, B_N, dig, son, mom);
      @(negedge clk);
      b_rst = 1'b0;
      @(posedge clk);
      #1 n = 0;
      while (!b_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check("b_latency", n, B_NPIX / B_L + B_N);
      check("b_digit", b_digit, dig);
      check("b_son", b_son, son);
      check("b_mom", b_mom, mom);
      b_ready = 1'b1;
      @(posedge clk);
      #1 b_ready = 1'b0;
      check("b_valid_drop", b_valid, 0);
      n = 0;
      idle_seen = 0;
      while (!b_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
         if (!b_busy) idle_seen++;
      end
      check("b_rerun_gap", n, B_CD + 1 + B_NPIX / B_L + B_N);
      check("b_idle_cycles", idle_seen, 1);
      check("b_rerun_digit", b_digit, dig);
      check("b_rerun_son", b_son, son);

      // All-zero image and templates: every mom is 0, class 0 kept.
      b_rst = 1'b1;
      #1;
      check("b_rst_valid", b_valid, 0);
      check("b_rst_son", b_son, 0);
      b_img = '0;
      b_masks = '0;
      @(negedge clk);
      b_rst = 1'b0;
      @(posedge clk);
      #1 n = 0;
      while (!b_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check("b_zero_latency", n, B_NPIX / B_L + B_N);
      check("b_zero_digit", b_digit, 0);
      check("b_zero_son", b_son, 0);
      check("b_zero_mom", b_mom, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
